// File: rtl/do_burst_sched.sv
// do_burst_sched: accepts burst requests, drives the downstream `do` line
// high for req_len cycles, then waits for the downstream completion pulse `f`.
// `do` is a reserved word in SystemVerilog, so the drive port is named do_line.
module do_burst_sched #(
  parameter int LEN_W   = 8,
  parameter int TO_W    = 6,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  output logic             do_line,
  input  logic             f,
  output logic             busy,
  output logic             done_pulse,
  output logic             timeout_err,
  output logic             proto_err,
  output logic [15:0]      burst_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_DONE, GAP} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic [TO_W-1:0]  to_cnt;

  logic accept, acc_burst, acc_null, last_drv, f_done, to_hit;

  assign accept    = req_valid && req_ready;
  assign acc_burst = accept && (req_len != '0);
  assign acc_null  = accept && (req_len == '0);
  assign last_drv  = (state == DRIVE) && (rem == LEN_W'(1));
  // f has priority over the timeout when both land on the same cycle
  assign f_done    = (state == WAIT_DONE) && f;
  assign to_hit    = (state == WAIT_DONE) && !f && (to_cnt == TO_W'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (acc_burst) state_nxt = DRIVE;
      DRIVE:     if (last_drv)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (f_done)    state_nxt = GAP;
                 else if (to_hit) state_nxt = IDLE;
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // status decoded from the registered state only (no path from req_valid)
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // burst datapath: length/timeout counters, drive line, status and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rem         <= '0;
      to_cnt      <= '0;
      do_line     <= 1'b0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      if (acc_burst)           rem <= req_len;
      else if (state == DRIVE) rem <= rem - LEN_W'(1);

      if (last_drv)                to_cnt <= '0;
      else if (state == WAIT_DONE) to_cnt <= to_cnt + TO_W'(1);

      do_line    <= (state_nxt == DRIVE);
      done_pulse <= acc_null || f_done;

      if (acc_burst)   timeout_err <= 1'b0;
      else if (to_hit) timeout_err <= 1'b1;

      // f while do is high means the downstream fired early
      if (acc_burst)                proto_err <= 1'b0;
      else if (state == DRIVE && f) proto_err <= 1'b1;

      if (f_done) burst_cnt <= burst_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_do_burst_sched.sv
// Bench for do_burst_sched: a downstream model answers each `do` fall with
// `f` two cycles later; expected run lengths and done counts go into queues
// that a negedge monitor pops as the DUT produces them.
module tb_do_burst_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_len = '0;
  logic        req_ready, do_line, f, busy, done_pulse, timeout_err, proto_err;
  logic [15:0] burst_cnt;

  logic f_model = 1'b0, inject = 1'b0, suppress = 1'b0, mon_en = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   exp_runs[$];
  int   exp_done[$];
  int   exp_cnt = 0;

  assign f = f_model | inject;

  do_burst_sched #(.LEN_W(8), .TO_W(6), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .do_line(do_line), .f(f), .busy(busy),
    .done_pulse(done_pulse), .timeout_err(timeout_err), .proto_err(proto_err),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // downstream model: f in cycle t+2 when do falls in cycle t
  logic prev_do_m = 1'b0, fall_d1 = 1'b0, fall_d2 = 1'b0;
  always @(negedge clk) begin
    f_model   = fall_d2 & ~suppress;
    fall_d2   = fall_d1;
    fall_d1   = prev_do_m & ~do_line;
    prev_do_m = do_line;
  end

  // monitor: do run lengths, gaps between runs, done_pulse vs burst count
  int  run = 0, gap = 0;
  bit  had_run = 0, prev_do = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (do_line) begin
        if (!prev_do && had_run) check("do_gap_ge4", int'(gap >= 4), 1);
        run++;
      end else begin
        if (prev_do) begin
          if (exp_runs.size() == 0) check("unexpected_do_run", run, -1);
          else check("do_run_len", run, exp_runs.pop_front());
          run = 0; had_run = 1; gap = 1;
        end else gap++;
      end
      prev_do = do_line;
      if (done_pulse) begin
        if (exp_done.size() == 0) check("unexpected_done", int'(burst_cnt), -1);
        else check("done_burst_cnt", int'(burst_cnt), exp_done.pop_front());
      end
    end
  end

  // present a request; returns at the negedge one cycle after acceptance
  task automatic send(input int len, input bit hold);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_len   = 8'(len);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("accept_timeout", 0, 1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic burst(input int len, input bit hold);
    exp_runs.push_back(len);
    exp_cnt++;
    exp_done.push_back(exp_cnt);
    send(len, hold);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_do", do_line, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_pulse, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_perr", proto_err, 0);
    check("rst_cnt", burst_cnt, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // len 3: do 1..3, f at 6, done at 7, ready again at 8
    burst(3, 0);
    check("t1_do_c1", do_line, 1);
    check("t1_ready_c1", req_ready, 0);
    repeat (5) @(negedge clk);
    check("t1_done_c6", done_pulse, 0);
    @(negedge clk);
    check("t1_done_c7", done_pulse, 1);
    check("t1_ready_c7", req_ready, 0);
    @(negedge clk);
    check("t1_ready_c8", req_ready, 1);
    check("t1_cnt", burst_cnt, 1);

    // valid held high across lengths 1 then 2
    burst(1, 1);
    burst(2, 0);
    repeat (8) @(negedge clk);
    check("t2_cnt", burst_cnt, exp_cnt);

    // null burst
    exp_done.push_back(exp_cnt);
    send(0, 0);
    check("t3_done", done_pulse, 1);
    check("t3_ready", req_ready, 1);
    check("t3_do", do_line, 0);
    check("t3_cnt", burst_cnt, exp_cnt);
    repeat (3) @(negedge clk);

    // suppressed f: timeout 40 cycles after do falls (fall at a+5)
    suppress = 1'b1;
    exp_runs.push_back(4);
    send(4, 0);
    repeat (43) @(negedge clk);
    check("t4_terr_early", timeout_err, 0);
    check("t4_busy_early", busy, 1);
    @(negedge clk);
    check("t4_terr", timeout_err, 1);
    check("t4_idle", busy, 0);
    check("t4_cnt", burst_cnt, exp_cnt);
    suppress = 1'b0;
    burst(1, 0);
    check("t4_terr_clr", timeout_err, 0);
    repeat (8) @(negedge clk);

    // f injected mid-DRIVE of a len-5 burst
    burst(5, 0);
    check("t5_perr_pre", proto_err, 0);
    @(negedge clk);
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("t5_perr", proto_err, 1);
    check("t5_do_still", do_line, 1);
    repeat (10) @(negedge clk);

    // max length
    burst(255, 0);
    repeat (262) @(negedge clk);
    check("t6_cnt", burst_cnt, exp_cnt);

    // reset mid-burst: do high cycles 1..2, rst sampled at end of cycle 2
    exp_runs.push_back(2);
    send(10, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("t7_do", do_line, 0);
    check("t7_busy", busy, 0);
    check("t7_ready", req_ready, 1);
    check("t7_cnt", burst_cnt, 0);
    check("t7_done", done_pulse, 0);
    repeat (10) @(negedge clk);

    check("runs_left", exp_runs.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
